// File: rtl/commit_retire_pkg.sv
// -----------------------------------------------------------------------------
// commit_retire_pkg
// Shared types for the retirement stage of the rename pipeline.
//   commit_state_t : retire FSM state (RUN / FLUSH)
//   ARCH_REG_COUNT : architectural register count
//   rob_head_t     : bundle of the ROB head fields, reusable by the ROB itself
// Optional feature macro used by the top: COMMIT_RVFI_EN
// -----------------------------------------------------------------------------
package commit_retire_pkg;

   localparam int ARCH_REG_COUNT    = 32;
   localparam int PHYS_REG_BITS_DEF = 6;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } commit_state_t;

   typedef struct packed {
      logic                         valid;
      logic                         ready;
      logic [4:0]                   rd;
      logic [PHYS_REG_BITS_DEF-1:0] pd;
      logic                         has_pd;
      logic                         mispredict;
      logic [31:0]                  target;
   } rob_head_t;

endpackage

// File: rtl/commit_retire_if.sv
// -----------------------------------------------------------------------------
// commit_retire_if
// Connects the retire stage to the ROB head, the free list and fetch redirect.
//   rob_head_*          : ROB head entry (from ROB)
//   rob_dequeue         : pop ROB head (to ROB)
//   fl_full             : free list cannot accept (from free list)
//   fl_enqueue/phys_reg : register being returned (to free list)
//   flush / flush_pc    : one-cycle redirect pulse (to fetch, ROB, RAT)
// Handshake: the head is consumed in a cycle exactly when rob_head_valid &&
// rob_head_ready are high and the retire unit raises rob_dequeue in that same
// cycle; a register is transferred to the free list exactly in a cycle where
// fl_enqueue is high, which the retire unit only does while fl_full is low.
// modport master = retire unit, modport slave = the ROB/free-list/fetch side.
// -----------------------------------------------------------------------------
interface commit_retire_if #(
   parameter int PHYS_REG_BITS = 6
);
   logic                     rob_head_valid;
   logic                     rob_head_ready;
   logic [4:0]               rob_head_rd;
   logic [PHYS_REG_BITS-1:0] rob_head_pd;
   logic                     rob_head_has_pd;
   logic                     rob_head_mispredict;
   logic [31:0]              rob_head_target;
   logic                     fl_full;
   logic                     rob_dequeue;
   logic                     fl_enqueue;
   logic [PHYS_REG_BITS-1:0] fl_phys_reg;
   logic                     flush;
   logic [31:0]              flush_pc;

   modport master (
      input  rob_head_valid, rob_head_ready, rob_head_rd, rob_head_pd,
             rob_head_has_pd, rob_head_mispredict, rob_head_target, fl_full,
      output rob_dequeue, fl_enqueue, fl_phys_reg, flush, flush_pc
   );

   modport slave (
      output rob_head_valid, rob_head_ready, rob_head_rd, rob_head_pd,
             rob_head_has_pd, rob_head_mispredict, rob_head_target, fl_full,
      input  rob_dequeue, fl_enqueue, fl_phys_reg, flush, flush_pc
   );
endinterface

// File: rtl/commit_retire_rrat_table.sv
// -----------------------------------------------------------------------------
// rrat_table
// Retirement RAT storage: ARCH_REGS entries, reset to identity (entry i = i).
//   clk_i, rst_i : clock, synchronous active-high reset (wins over a write)
//   we_i/waddr_i/wdata_i : single write port
//   raddr_i/rdata_o      : combinational read of the current (old) mapping
//   rrat_map_o           : flat registered image, entry i at [i*W +: W]
// -----------------------------------------------------------------------------
module rrat_table #(
   parameter int PHYS_REG_BITS = 6,
   parameter int ARCH_REGS     = 32
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               we_i,
   input  logic [4:0]                         waddr_i,
   input  logic [PHYS_REG_BITS-1:0]           wdata_i,
   input  logic [4:0]                         raddr_i,
   output logic [PHYS_REG_BITS-1:0]           rdata_o,
   output logic [ARCH_REGS*PHYS_REG_BITS-1:0] rrat_map_o
);

   logic [PHYS_REG_BITS-1:0] rrat_q [ARCH_REGS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            rrat_q[i] <= PHYS_REG_BITS'(i);
         end
      end else if (we_i) begin
         rrat_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = rrat_q[raddr_i];

   for (genvar g = 0; g < ARCH_REGS; g++) begin : g_map
      assign rrat_map_o[g*PHYS_REG_BITS +: PHYS_REG_BITS] = rrat_q[g];
   end

endmodule

// File: rtl/commit_retire.sv
// -----------------------------------------------------------------------------
// commit_retire
// Retires the ROB head in program order, updates the retirement RAT, returns
// superseded physical registers to the free list and raises a one-cycle flush
// (redirect PC + RRAT image) when a mispredicted control-flow op retires.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : commit_retire_if.master (ROB head, free list, flush)
//   rrat_map     : registered RRAT image, entry i at [i*PHYS_REG_BITS +: ...]
//   commit_count : retired-instruction counter (wraps)
//   state_dbg_o  : current FSM state
// Optional (macro COMMIT_RVFI_EN): rvfi_valid, rvfi_order, rvfi_rd_addr,
// rvfi_pd describe each retirement in the cycle it happens.
// -----------------------------------------------------------------------------
module commit_retire
   import commit_retire_pkg::*;
#(
   parameter int PHYS_REG_BITS = 6,
   parameter int ARCH_REGS     = ARCH_REG_COUNT
) (
   input  logic                               clk,
   input  logic                               rst,
   commit_retire_if.master                    bus,
   output logic [ARCH_REGS*PHYS_REG_BITS-1:0] rrat_map,
   output logic [31:0]                        commit_count,
   output commit_state_t                      state_dbg_o
`ifdef COMMIT_RVFI_EN
   ,
   output logic                               rvfi_valid,
   output logic [63:0]                        rvfi_order,
   output logic [4:0]                         rvfi_rd_addr,
   output logic [PHYS_REG_BITS-1:0]           rvfi_pd
`endif
);

   commit_state_t            state_q, state_d;
   logic [31:0]              flush_pc_q, flush_pc_d;
   logic [31:0]              count_q, count_d;
   logic                     need_free;
   logic                     commit;
   logic                     rrat_we;
   logic [PHYS_REG_BITS-1:0] old_pd;

   assign need_free = bus.rob_head_has_pd;

   // Reset also blocks the commit so a retirement in a reset cycle is dropped.
   assign commit = !rst && (state_q == RUN) && bus.rob_head_valid &&
                   bus.rob_head_ready && !(need_free && bus.fl_full);

   // x0 is hard-wired: its mapping never changes, the allocation goes back.
   assign rrat_we = commit && need_free && (bus.rob_head_rd != 5'd0);

   rrat_table #(
      .PHYS_REG_BITS (PHYS_REG_BITS),
      .ARCH_REGS     (ARCH_REGS)
   ) u_rrat (
      .clk_i      (clk),
      .rst_i      (rst),
      .we_i       (rrat_we),
      .waddr_i    (bus.rob_head_rd),
      .wdata_i    (bus.rob_head_pd),
      .raddr_i    (bus.rob_head_rd),
      .rdata_o    (old_pd),
      .rrat_map_o (rrat_map)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         flush_pc_q <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         flush_pc_q <= flush_pc_d;
         count_q    <= count_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      flush_pc_d = flush_pc_q;
      count_d    = count_q;
      case (state_q)
         RUN: begin
            if (commit) begin
               count_d = count_q + 32'd1;
               if (bus.rob_head_mispredict) begin
                  flush_pc_d = bus.rob_head_target;
                  state_d    = FLUSH;
               end
            end
         end
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Output logic
   always_comb begin
      bus.rob_dequeue = 1'b0;
      bus.fl_enqueue  = 1'b0;
      bus.fl_phys_reg = '0;
      bus.flush       = 1'b0;
      case (state_q)
         RUN: begin
            bus.rob_dequeue = commit;
            if (commit && need_free) begin
               bus.fl_enqueue  = 1'b1;
               bus.fl_phys_reg = (bus.rob_head_rd == 5'd0) ? bus.rob_head_pd : old_pd;
            end
         end
         FLUSH:   bus.flush = 1'b1;
         default: bus.flush = 1'b0;
      endcase
   end

   assign bus.flush_pc = flush_pc_q;
   assign commit_count = count_q;
   assign state_dbg_o  = state_q;

`ifdef COMMIT_RVFI_EN
   logic [63:0] order_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         order_q <= '0;
      end else if (commit) begin
         order_q <= order_q + 64'd1;
      end
   end

   assign rvfi_valid   = commit;
   assign rvfi_order   = order_q;
   assign rvfi_rd_addr = need_free ? bus.rob_head_rd : 5'd0;
   assign rvfi_pd      = bus.rob_head_pd;
`endif

endmodule

// File: tb/tb_commit_retire.sv
// -----------------------------------------------------------------------------
// tb_commit_retire
// Bench for commit_retire: freed registers are predicted from a bench-side
// RRAT model and queued when a head is driven, then popped when fl_enqueue
// appears. Honours COMMIT_RVFI_EN when defined.
// -----------------------------------------------------------------------------
module tb_commit_retire;
   import commit_retire_pkg::*;

   localparam int PRB = 6;
   localparam int AR  = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   commit_retire_if #(.PHYS_REG_BITS(PRB)) bus ();
   logic [AR*PRB-1:0] rrat_map;
   logic [31:0]       commit_count;
   commit_state_t     state_dbg;
`ifdef COMMIT_RVFI_EN
   logic              rvfi_valid;
   logic [63:0]       rvfi_order;
   logic [4:0]        rvfi_rd_addr;
   logic [PRB-1:0]    rvfi_pd;
`endif

   commit_retire #(.PHYS_REG_BITS(PRB), .ARCH_REGS(AR)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.master),
      .rrat_map     (rrat_map),
      .commit_count (commit_count),
      .state_dbg_o  (state_dbg)
`ifdef COMMIT_RVFI_EN
      ,
      .rvfi_valid   (rvfi_valid),
      .rvfi_order   (rvfi_order),
      .rvfi_rd_addr (rvfi_rd_addr),
      .rvfi_pd      (rvfi_pd)
`endif
   );

   // ---------------- model / scoreboard ----------------
   int             checks = 0;
   int             errors = 0;
   logic [PRB-1:0] m_rrat [AR];
   logic [31:0]    m_count;
   logic [31:0]    m_flush_pc;
   logic [PRB-1:0] exp_q [$];
`ifdef COMMIT_RVFI_EN
   logic [63:0]    m_order;
`endif

   function automatic logic [AR*PRB-1:0] model_map();
      logic [AR*PRB-1:0] m;
      for (int i = 0; i < AR; i++) m[i*PRB +: PRB] = m_rrat[i];
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < AR; i++) m_rrat[i] = PRB'(i);
      m_count    = 32'd0;
      m_flush_pc = 32'd0;
      exp_q.delete();
`ifdef COMMIT_RVFI_EN
      m_order = 64'd0;
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_head(input logic v, input logic r, input logic [4:0] rd,
                             input logic [PRB-1:0] pd, input logic hp,
                             input logic mp, input logic [31:0] tgt);
      bus.rob_head_valid      = v;
      bus.rob_head_ready      = r;
      bus.rob_head_rd         = rd;
      bus.rob_head_pd         = pd;
      bus.rob_head_has_pd     = hp;
      bus.rob_head_mispredict = mp;
      bus.rob_head_target     = tgt;
   endtask

   task automatic drive_idle();
      drive_head(1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0, 32'd0);
   endtask

   // One clock with head already driven (entered at negedge).
   task automatic cycle(input string name, input bit exp_commit, input bit exp_flush);
      bit             exp_enq;
      logic [PRB-1:0] want;
      #1;
      exp_enq = exp_commit && bus.rob_head_has_pd;
      checks++;
      if (bus.rob_dequeue !== exp_commit) begin
         errors++;
         $display("FAIL %s rob_dequeue got %b want %b", name, bus.rob_dequeue, exp_commit);
      end
      checks++;
      if (bus.fl_enqueue !== exp_enq) begin
         errors++;
         $display("FAIL %s fl_enqueue got %b want %b", name, bus.fl_enqueue, exp_enq);
      end
      if (exp_enq) exp_q.push_back((bus.rob_head_rd == 5'd0) ? bus.rob_head_pd : m_rrat[bus.rob_head_rd]);
      if (bus.fl_enqueue === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s fl_phys_reg got %0d want no enqueue", name, bus.fl_phys_reg);
         end else begin
            want = exp_q.pop_front();
            if (bus.fl_phys_reg !== want) begin
               errors++;
               $display("FAIL %s fl_phys_reg got %0d want %0d", name, bus.fl_phys_reg, want);
            end
         end
      end else if (exp_enq) begin
         void'(exp_q.pop_front());
      end
      checks++;
      if (bus.flush !== exp_flush) begin
         errors++;
         $display("FAIL %s flush got %b want %b", name, bus.flush, exp_flush);
      end
      if (exp_flush) begin
         checks++;
         if (bus.flush_pc !== m_flush_pc) begin
            errors++;
            $display("FAIL %s flush_pc got %h want %h", name, bus.flush_pc, m_flush_pc);
         end
      end
`ifdef COMMIT_RVFI_EN
      checks++;
      if (rvfi_valid !== exp_commit) begin
         errors++;
         $display("FAIL %s rvfi_valid got %b want %b", name, rvfi_valid, exp_commit);
      end
      if (exp_commit) begin
         checks++;
         if (rvfi_order !== m_order) begin
            errors++;
            $display("FAIL %s rvfi_order got %0d want %0d", name, rvfi_order, m_order);
         end
      end
`endif
      @(posedge clk);
      if (exp_commit) begin
         m_count = m_count + 32'd1;
         if (bus.rob_head_has_pd && bus.rob_head_rd != 5'd0) m_rrat[bus.rob_head_rd] = bus.rob_head_pd;
         if (bus.rob_head_mispredict) m_flush_pc = bus.rob_head_target;
`ifdef COMMIT_RVFI_EN
         m_order = m_order + 64'd1;
`endif
      end
      #1;
      checks++;
      if (commit_count !== m_count) begin
         errors++;
         $display("FAIL %s commit_count got %0d want %0d", name, commit_count, m_count);
      end
      checks++;
      if (rrat_map !== model_map()) begin
         errors++;
         $display("FAIL %s rrat_map got %h want %h", name, rrat_map, model_map());
      end
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.fl_full = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.rob_dequeue !== 1'b0 || bus.fl_enqueue !== 1'b0 || bus.fl_phys_reg !== '0) begin
         errors++;
         $display("FAIL reset_outs got deq=%b enq=%b reg=%0d want 0 0 0",
                  bus.rob_dequeue, bus.fl_enqueue, bus.fl_phys_reg);
      end
      checks++;
      if (bus.flush !== 1'b0 || bus.flush_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_flush got flush=%b pc=%h want 0 0", bus.flush, bus.flush_pc);
      end
      checks++;
      if (commit_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_count got %0d want 0", commit_count);
      end
      checks++;
      if (rrat_map !== model_map()) begin
         errors++;
         $display("FAIL reset_rrat got %h want %h", rrat_map, model_map());
      end
      checks++;
      if (state_dbg !== RUN) begin
         errors++;
         $display("FAIL reset_state got %0d want %0d", state_dbg, RUN);
      end
   endtask

   task automatic test_basic_commit();
      drive_head(1'b1, 1'b1, 5'd5, 6'd40, 1'b1, 1'b0, 32'd0);
      cycle("commit_rd5", 1'b1, 1'b0);
      checks++;
      if (rrat_map[5*PRB +: PRB] !== 6'd40) begin
         errors++;
         $display("FAIL rrat5 got %0d want 40", rrat_map[5*PRB +: PRB]);
      end
      drive_head(1'b1, 1'b1, 5'd0, 6'd33, 1'b1, 1'b0, 32'd0);
      cycle("commit_x0", 1'b1, 1'b0);
      checks++;
      if (rrat_map[0 +: PRB] !== 6'd0) begin
         errors++;
         $display("FAIL rrat0 got %0d want 0", rrat_map[0 +: PRB]);
      end
      drive_head(1'b1, 1'b0, 5'd4, 6'd39, 1'b1, 1'b0, 32'd0);
      cycle("not_ready", 1'b0, 1'b0);
      drive_head(1'b0, 1'b1, 5'd4, 6'd39, 1'b1, 1'b0, 32'd0);
      cycle("rob_empty", 1'b0, 1'b0);
   endtask

   task automatic test_branch_mispredict();
      drive_head(1'b1, 1'b1, 5'd0, 6'd0, 1'b0, 1'b1, 32'h6000_0100);
      cycle("br_commit", 1'b1, 1'b0);
      drive_head(1'b1, 1'b1, 5'd6, 6'd42, 1'b1, 1'b0, 32'd0);
      cycle("br_flush", 1'b0, 1'b1);
      cycle("br_resume", 1'b1, 1'b0);
   endtask

   task automatic test_fl_full();
      bus.fl_full = 1'b1;
      drive_head(1'b1, 1'b1, 5'd10, 6'd41, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) cycle("full_stall", 1'b0, 1'b0);
      drive_head(1'b1, 1'b1, 5'd0, 6'd0, 1'b0, 1'b0, 32'd0);
      cycle("full_nopd", 1'b1, 1'b0);
      drive_head(1'b1, 1'b1, 5'd10, 6'd41, 1'b1, 1'b0, 32'd0);
      cycle("full_stall2", 1'b0, 1'b0);
      bus.fl_full = 1'b0;
      cycle("full_drop", 1'b1, 1'b0);
   endtask

   task automatic test_jal_mispredict();
      drive_head(1'b1, 1'b1, 5'd1, 6'd45, 1'b1, 1'b1, 32'h0000_1234);
      cycle("jal_commit", 1'b1, 1'b0);
      drive_head(1'b1, 1'b1, 5'd2, 6'd46, 1'b1, 1'b0, 32'd0);
      #1;
      checks++;
      if (rrat_map[1*PRB +: PRB] !== 6'd45) begin
         errors++;
         $display("FAIL jal_rrat1 got %0d want 45", rrat_map[1*PRB +: PRB]);
      end
      cycle("jal_flush", 1'b0, 1'b1);
      cycle("jal_resume", 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      drive_head(1'b1, 1'b1, 5'd7, 6'd50, 1'b1, 1'b0, 32'd0);
      cycle("b2b_first", 1'b1, 1'b0);
      drive_head(1'b1, 1'b1, 5'd7, 6'd51, 1'b1, 1'b1, 32'h7000_0000);
      cycle("b2b_second", 1'b1, 1'b0);
      // reset during the flush cycle
      drive_head(1'b1, 1'b1, 5'd9, 6'd60, 1'b1, 1'b0, 32'd0);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.flush !== 1'b1) begin
         errors++;
         $display("FAIL rst_flush_pre got %b want 1", bus.flush);
      end
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
      drive_idle();
      checks++;
      if (bus.flush !== 1'b0) begin
         errors++;
         $display("FAIL rst_flush_post got %b want 0", bus.flush);
      end
      checks++;
      if (rrat_map !== model_map() || commit_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_flush_state got %h/%0d want %h/0", rrat_map, commit_count, model_map());
      end
      @(negedge clk);
      // reset during a would-be commit: RRAT write must be discarded
      drive_head(1'b1, 1'b1, 5'd3, 6'd20, 1'b1, 1'b0, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_idle();
      checks++;
      if (rrat_map[3*PRB +: PRB] !== 6'd3 || commit_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_commit got rrat3=%0d cnt=%0d want 3 0", rrat_map[3*PRB +: PRB], commit_count);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      bit in_flush = 1'b0;
      bit v, r, hp, mp, full, exp_c;
      for (int i = 0; i < 60; i++) begin
         v    = ($urandom_range(0, 3) != 0);
         r    = ($urandom_range(0, 3) != 0);
         hp   = ($urandom_range(0, 3) != 0);
         mp   = ($urandom_range(0, 5) == 0);
         full = ($urandom_range(0, 3) == 0);
         bus.fl_full = full;
         drive_head(v, r, 5'($urandom_range(0, 31)), PRB'($urandom_range(32, 63)), hp, mp,
                    32'($urandom_range(0, 32'hFFFF)) << 2);
         exp_c = !in_flush && v && r && !(hp && full);
         cycle("rand", exp_c, in_flush);
         in_flush = exp_c && mp;
      end
      bus.fl_full = 1'b0;
      drive_idle();
      cycle("rand_tail", 1'b0, in_flush);
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_basic_commit();
      test_branch_mispredict();
      test_fl_full();
      test_jal_mispredict();
      test_back_to_back();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
